lifo_stack: RTL and testbench

//  LIFO stack, 1024 x 8 bit, with a single bidirectional data bus.
//  One direction line selects push or pop; an enable qualifies the operation.

---
 rtl/lifo_stack_pkg.sv | 22 ++
 rtl/lifo_stack_if.sv | 27 ++
 rtl/lifo_stack_mem.sv | 35 +++
 rtl/lifo_stack.sv | 89 ++++++++
 tb/tb_lifo_stack.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/lifo_stack_pkg.sv
// Shared constants and types for the 1024 x 8 LIFO stack.
// Imported by the interface-facing top and the storage sub-module.
package lifo_stack_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_e;

    // Entry count at which the stack reports full.
    function automatic logic [PTR_W-1:0] full_count();
        return PTR_W'(DEPTH);
    endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Control and status bundle for lifo_stack. The shared tri-state data bus
// stays a plain inout on the top so it can be resolved alongside other bus drivers.
interface lifo_stack_if;

    logic enable;
    logic push_pop;
    logic empty;
    logic full;
    logic ovf_err;

    modport master (
        output enable,
        output push_pop,
        input  empty,
        input  full,
        input  ovf_err
    );

    modport slave (
        input  enable,
        input  push_pop,
        output empty,
        output full,
        output ovf_err
    );

endinterface

// File: rtl/lifo_stack_mem.sv
// Single-port synchronous RAM for the stack: one write port and a registered
// read port sharing one address; the read register clears on reset.
module lifo_stack_mem
    import lifo_stack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  data_t             wr_data,
    output data_t             rd_data
);

    data_t mem [DEPTH];
    data_t rd_data_reg;

    // Storage is never cleared; only the pointer defines valid contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/lifo_stack.sv
// 1024 x 8 LIFO stack behind a shared tri-state data bus.
// Optional sticky misuse flag built only when LIFO_STACK_OVF_ERR_EN is defined.
module lifo_stack
    import lifo_stack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    lifo_stack_if.slave       ctl,
    inout  wire  [DATA_W-1:0] data_io
);

    logic [PTR_W-1:0]  sp_reg;
    logic [PTR_W-1:0]  sp_next;
    logic [PTR_W-1:0]  sp_m1;
    logic [ADDR_W-1:0] mem_addr;
    op_e               op;
    logic              is_empty;
    logic              is_full;
    logic              do_push;
    logic              do_pop;
    logic              bus_drive;
    data_t             rd_q;

    assign op       = op_e'(ctl.push_pop);
    assign is_empty = (sp_reg == '0);
    assign is_full  = (sp_reg == full_count());

    // Gating with rst keeps a reset cycle from writing or reading the RAM.
    assign do_push = rst && ctl.enable && (op == OP_PUSH) && !is_full;
    assign do_pop  = rst && ctl.enable && (op == OP_POP)  && !is_empty;

    always_comb begin
        sp_next = sp_reg;
        if (do_push) begin
            sp_next = sp_reg + PTR_W'(1);
        end else if (do_pop) begin
            sp_next = sp_reg - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_reg <= '0;
        end else begin
            sp_reg <= sp_next;
        end
    end

    // Push writes the next free slot; pop reads the top entry.
    assign sp_m1    = sp_reg - PTR_W'(1);
    assign mem_addr = do_pop ? sp_m1[ADDR_W-1:0] : sp_reg[ADDR_W-1:0];

    lifo_stack_mem u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (do_push),
        .rd_en   (do_pop),
        .addr    (mem_addr),
        .wr_data (data_io),
        .rd_data (rd_q)
    );

    assign ctl.empty = is_empty;
    assign ctl.full  = is_full;

    assign bus_drive = rst && (op == OP_POP);

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bus
        assign data_io[gi] = bus_drive ? rd_q[gi] : 1'bz;
    end

`ifdef LIFO_STACK_OVF_ERR_EN
    logic ovf_err_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_err_reg <= 1'b0;
        end else if (ctl.enable &&
                     (((op == OP_PUSH) && is_full) || ((op == OP_POP) && is_empty))) begin
            ovf_err_reg <= 1'b1;
        end
    end

    assign ctl.ovf_err = ovf_err_reg;
`else
    assign ctl.ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack: stimulus queues expected pop data, a monitor
// compares the bus one cycle after every enabled pop.
module tb_lifo_stack;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tb_drv = 1'b0;
    logic [7:0] tb_val = 8'h00;
    wire  [7:0] data_io;

    int chk_cnt = 0;
    int err_cnt = 0;

    logic [7:0] exp_q[$];

`ifdef LIFO_STACK_OVF_ERR_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    lifo_stack_if ctl ();

    lifo_stack dut (
        .clk     (clk),
        .rst     (rst),
        .ctl     (ctl),
        .data_io (data_io)
    );

    assign data_io = tb_drv ? tb_val : 8'bz;

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    // Inputs are applied 2ns after an edge and held through the next edge.
    task automatic step(input logic en, input logic pp, input logic [7:0] d);
        ctl.enable   = en;
        ctl.push_pop = pp;
        tb_drv       = !pp;
        tb_val       = d;
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b1, 1'b0, d);
    endtask

    task automatic pop(input logic [7:0] expd);
        exp_q.push_back(expd);
        step(1'b1, 1'b1, 8'h00);
    endtask

    // Monitor: a pop is presented on the bus right after the edge that completes it.
    always @(posedge clk) begin
        logic pend;
        pend = rst && ctl.enable && ctl.push_pop;
        #1;
        if (pend) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                err_cnt++;
                $display("FAIL sb_underrun: got %0h expected none", data_io);
            end else begin
                check("pop_data", int'(data_io), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        ctl.enable   = 1'b0;
        ctl.push_pop = 1'b0;

        // 1 reset, bus held by bench with push_pop=0
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h5A);
        step(1'b0, 1'b0, 8'h5A);
        check("rst_empty", int'(ctl.empty), 1);
        check("rst_full", int'(ctl.full), 0);
        check("rst_ovf", int'(ctl.ovf_err), 0);
        check("rst_bus_undriven", int'(data_io), 8'h5A);
        rst = 1'b1;

        // 2 fill
        for (int i = 0; i < 1023; i++) begin
            push(8'((2 * i) % 256));
            if (i == 0) check("empty_after_first_push", int'(ctl.empty), 0);
        end
        check("not_full_at_1023", int'(ctl.full), 0);
        push(8'hFE);
        check("full_at_1024", int'(ctl.full), 1);
        check("ovf_before_overflow", int'(ctl.ovf_err), 0);

        // 3 overflow
        push(8'h55);
        check("full_after_overflow", int'(ctl.full), 1);
        check("ovf_after_overflow", int'(ctl.ovf_err), int'(OVF_ON));

        // 4 drain: FE first, then the fill pattern in reverse
        for (int k = 0; k < 1024; k++) begin
            if (k == 0) pop(8'hFE);
            else        pop(8'((2 * (1023 - k)) % 256));
            if (k == 0)    check("not_full_after_pop", int'(ctl.full), 0);
            if (k == 1022) check("not_empty_at_1023_pops", int'(ctl.empty), 0);
        end
        check("empty_after_drain", int'(ctl.empty), 1);

        // 5 underflow: bus keeps the last popped value
        pop(8'h00);
        check("empty_after_underflow", int'(ctl.empty), 1);
        check("ovf_after_underflow", int'(ctl.ovf_err), int'(OVF_ON));

        // clear sticky flag before interleave
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        check("ovf_cleared", int'(ctl.ovf_err), 0);

        // 6 interleave
        push(8'hA1);
        push(8'hB2);
        pop(8'hB2);
        push(8'hC3);
        pop(8'hC3);
        pop(8'hA1);
        check("empty_after_interleave", int'(ctl.empty), 1);

        // idle cycle must not consume the entry
        push(8'h77);
        step(1'b0, 1'b1, 8'h00);
        check("idle_not_empty", int'(ctl.empty), 0);
        pop(8'h77);

        // reset mid-sequence with a push in flight
        push(8'h11);
        push(8'h22);
        rst = 1'b0;
        push(8'h33);
        check("midrst_empty", int'(ctl.empty), 1);
        check("midrst_full", int'(ctl.full), 0);
        rst = 1'b1;
        // rd_q was cleared, so an underflow pop shows 00
        pop(8'h00);
        check("empty_after_midrst_pop", int'(ctl.empty), 1);
        check("ovf_after_midrst_pop", int'(ctl.ovf_err), int'(OVF_ON));

        step(1'b0, 1'b0, 8'h00);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
